sort_datapath: RTL

SORT_DATAPATH -- requirements
Module: sort_datapath

---
 rtl/sort_datapath.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sort_datapath.sv
// -----------------------------------------------------------------------------
// sort_datapath
//   Datapath for an in-place compare-and-swap sort over an N x W word array.
//   An external controller steers it with single-bit control strobes and
//   reacts to the status flags it returns.
//
// Ports
//   clk      in   clock, all state updates on the rising edge
//   rst      in   asynchronous active-high reset (indices and A/B only)
//   ld_en    in   host write strobe into the array
//   ld_addr  in   host write address
//   ld_data  in   host write data
//   rd_addr  in   host read address
//   rd_data  out  combinational read of M[rd_addr]
//   EA, EB   in   load A / B from M[addr]
//   WR       in   write M[addr] with B (Bout=1) or A (Bout=0)
//   Li, Ei   in   clear / increment index i (Li wins)
//   Lj, Ej   in   load j with i+1 / increment j (Lj wins)
//   Csel     in   array address select: 0 -> i, 1 -> j
//   Bout     in   write data select: 1 -> B, 0 -> A
//   zi       out  i == N-2
//   zj       out  j == N-1
//   AgtB     out  A > B, unsigned
//   Sw_flag  out  i <= N-2, an unsorted pair remains
// -----------------------------------------------------------------------------
module sort_datapath #(
  parameter int N = 8,
  parameter int W = 8,
  localparam int IW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [IW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic [IW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          EA,
  input  logic          EB,
  input  logic          WR,
  input  logic          Li,
  input  logic          Lj,
  input  logic          Ei,
  input  logic          Ej,
  input  logic          Csel,
  input  logic          Bout,
  output logic          zi,
  output logic          zj,
  output logic          AgtB,
  output logic          Sw_flag
);

  localparam logic [IW-1:0] I_LAST = IW'(N - 2);
  localparam logic [IW-1:0] J_LAST = IW'(N - 1);

  logic [W-1:0]  mem_q [N];
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;

  logic [IW-1:0] addr_s;
  logic [W-1:0]  mem_rd_s;
  logic          we_s;
  logic [IW-1:0] waddr_s;
  logic [W-1:0]  wdata_s;

  // Array address mux and the datapath read port feeding A and B.
  always_comb begin
    if (Csel) begin
      addr_s = j_q;
    end else begin
      addr_s = i_q;
    end
    mem_rd_s = mem_q[addr_s];
  end

  // Array write arbitration: the datapath write beats the host write.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = ld_addr;
    wdata_s = ld_data;
    if (WR) begin
      we_s    = 1'b1;
      waddr_s = addr_s;
      if (Bout) begin
        wdata_s = b_q;
      end else begin
        wdata_s = a_q;
      end
    end else if (ld_en) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Next-state for the indices and the A/B holding registers.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    a_d = a_q;
    b_d = b_q;
    if (Li) begin
      i_d = '0;
    end else if (Ei) begin
      i_d = i_q + IW'(1);
    end else begin
      i_d = i_q;
    end
    // j loads from the pre-edge i, so Li/Ei in the same cycle do not affect it.
    if (Lj) begin
      j_d = i_q + IW'(1);
    end else if (Ej) begin
      j_d = j_q + IW'(1);
    end else begin
      j_d = j_q;
    end
    if (EA) begin
      a_d = mem_rd_s;
    end else begin
      a_d = a_q;
    end
    if (EB) begin
      b_d = mem_rd_s;
    end else begin
      b_d = b_q;
    end
  end

  // Index and A/B state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Array storage: intentionally not reset so a reset mid-sort keeps the data.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  // Host read port and status flags, all combinational.
  always_comb begin
    rd_data = mem_q[rd_addr];
    zi      = (i_q == I_LAST);
    zj      = (j_q == J_LAST);
    AgtB    = (a_q > b_q);
    Sw_flag = (i_q <= I_LAST);
  end

endmodule
